// File: rtl/edge_detector_pkg.sv
// Shared types and limits for the edge detector.
package edge_detector_pkg;

  // Edge-selection modes for the pulse output.
  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  // Deepest synchroniser chain supported.
  localparam int SYNC_STAGES_MAX = 4;

endpackage : edge_detector_pkg

// File: rtl/edge_detector_sync_bit_sync.sv
// bit_sync: N-stage flop chain with asynchronous reset to RESET_VAL.
// N = 0 degenerates to a straight wire for inputs already synchronous to clk.
module bit_sync #(
  parameter int   N         = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (N == 0) begin : g_bypass
      assign q = d;
    end else begin : g_chain
      logic [N-1:0] stage_reg;

      // Shift the input through the chain, stage 0 first.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage_reg <= {N{RESET_VAL}};
        end else begin
          stage_reg[0] <= d;
          for (int i = 1; i < N; i++) begin
            stage_reg[i] <= stage_reg[i-1];
          end
        end
      end

      assign q = stage_reg[N-1];
    end
  endgenerate

endmodule : bit_sync

// File: rtl/edge_detector_sync.sv
// edge_detector_sync: synchronise a level and emit registered one-cycle
// pulses on rising, falling or both edges.
// Optional debug edge counter is compiled in with EDGE_DETECTOR_CNT_EN.
module edge_detector_sync
  import edge_detector_pkg::*;
#(
  parameter int   MODE        = 0,
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0,
  parameter int   CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signal,
  output logic             pulse,
  output logic             rise,
  output logic             fall,
`ifdef EDGE_DETECTOR_CNT_EN
  output logic             level,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] edge_cnt
`else
  output logic             level
`endif
);

  // Reject illegal configurations at elaboration time.
  generate
    if (!(MODE == int'(EDGE_RISE) || MODE == int'(EDGE_FALL) || MODE == int'(EDGE_BOTH))) begin : g_bad_mode
      $error("edge_detector_sync: MODE must be 0, 1 or 2");
    end
    if (SYNC_STAGES < 0 || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("edge_detector_sync: SYNC_STAGES out of range");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("edge_detector_sync: CNT_W must be at least 1");
    end
  endgenerate

  localparam edge_mode_e MODE_SEL = edge_mode_e'(MODE[1:0]);

  logic sync_s;
  logic prev_reg;
  logic rise_d;
  logic fall_d;
  logic pulse_d;
  logic rise_reg;
  logic fall_reg;
  logic pulse_reg;

  bit_sync #(
    .N         (SYNC_STAGES),
    .RESET_VAL (RESET_LEVEL)
  ) u_bit_sync (
    .clk (clk),
    .rst (rst),
    .d   (signal),
    .q   (sync_s)
  );

  assign rise_d = sync_s & ~prev_reg;
  assign fall_d = ~sync_s & prev_reg;

  // Choose which edge terms drive pulse.
  always_comb begin
    pulse_d = 1'b0;
    case (MODE_SEL)
      EDGE_RISE: pulse_d = rise_d;
      EDGE_FALL: pulse_d = fall_d;
      EDGE_BOTH: pulse_d = rise_d | fall_d;
      default:   pulse_d = 1'b0;
    endcase
  end

  // History flop and registered edge outputs; reset starts from RESET_LEVEL
  // so a differing input at release is seen as an ordinary edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg  <= RESET_LEVEL;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      prev_reg  <= sync_s;
      rise_reg  <= rise_d;
      fall_reg  <= fall_d;
      pulse_reg <= pulse_d;
    end
  end

  assign pulse = pulse_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;
  assign level = sync_s;

`ifdef EDGE_DETECTOR_CNT_EN
  logic [CNT_W-1:0] cnt_reg;

  // Count pulse assertions; clear has priority over a coincident pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (cnt_clr) begin
      cnt_reg <= '0;
    end else if (pulse_reg) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign edge_cnt = cnt_reg;
`endif

endmodule : edge_detector_sync

// File: tb/tb_edge_detector_sync.sv
// Directed testbench for edge_detector_sync (several parameterisations
// sharing one stimulus line).
module tb_edge_detector_sync;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic signal = 1'b0;

  int total = 0;
  int bad   = 0;

  logic m0_pulse, m0_rise, m0_fall, m0_level;
  logic m1_pulse, m1_rise, m1_fall, m1_level;
  logic m2_pulse, m2_rise, m2_fall, m2_level;
  logic z_pulse,  z_rise,  z_fall,  z_level;

`ifdef EDGE_DETECTOR_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [15:0] m0_cnt, m1_cnt, m2_cnt, z_cnt;
  logic        c_pulse, c_rise, c_fall, c_level;
  logic [2:0]  c_cnt;
`endif

  always #5 clk = ~clk;

  edge_detector_sync #(.MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .signal(signal),
    .pulse(m0_pulse), .rise(m0_rise), .fall(m0_fall),
`ifdef EDGE_DETECTOR_CNT_EN
    .level(m0_level), .cnt_clr(cnt_clr), .edge_cnt(m0_cnt)
`else
    .level(m0_level)
`endif
  );

  edge_detector_sync #(.MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .signal(signal),
    .pulse(m1_pulse), .rise(m1_rise), .fall(m1_fall),
`ifdef EDGE_DETECTOR_CNT_EN
    .level(m1_level), .cnt_clr(cnt_clr), .edge_cnt(m1_cnt)
`else
    .level(m1_level)
`endif
  );

  edge_detector_sync #(.MODE(2)) u_m2 (
    .clk(clk), .rst(rst), .signal(signal),
    .pulse(m2_pulse), .rise(m2_rise), .fall(m2_fall),
`ifdef EDGE_DETECTOR_CNT_EN
    .level(m2_level), .cnt_clr(cnt_clr), .edge_cnt(m2_cnt)
`else
    .level(m2_level)
`endif
  );

  edge_detector_sync #(.MODE(2), .SYNC_STAGES(0)) u_z (
    .clk(clk), .rst(rst), .signal(signal),
    .pulse(z_pulse), .rise(z_rise), .fall(z_fall),
`ifdef EDGE_DETECTOR_CNT_EN
    .level(z_level), .cnt_clr(cnt_clr), .edge_cnt(z_cnt)
`else
    .level(z_level)
`endif
  );

`ifdef EDGE_DETECTOR_CNT_EN
  edge_detector_sync #(.MODE(0), .CNT_W(3)) u_c (
    .clk(clk), .rst(rst), .signal(signal),
    .pulse(c_pulse), .rise(c_rise), .fall(c_fall),
    .level(c_level), .cnt_clr(cnt_clr), .edge_cnt(c_cnt)
  );
`endif

  // One clock; leaves time just after the rising edge for drive and sample.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic lvl);
    signal = lvl;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    signal = 1'b0;
    step();
    total++; if (m0_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", m0_pulse); end
    total++; if (m0_rise  !== 1'b0) begin bad++; $display("FAIL reset_rise got=%b exp=0", m0_rise); end
    total++; if (m0_fall  !== 1'b0) begin bad++; $display("FAIL reset_fall got=%b exp=0", m0_fall); end
    total++; if (m0_level !== 1'b0) begin bad++; $display("FAIL reset_level got=%b exp=0", m0_level); end
    total++; if (m2_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse_m2 got=%b exp=0", m2_pulse); end
    $display("test_reset: checks=%0d", total);
  endtask

  // 5 x (15 high, 7 low); MODE 0 plus the zero-stage instance.
  task automatic test_mode_rise();
    int n_p = 0, n_r = 0, n_f = 0;
    do_reset(1'b0);
    repeat (3) step();
    for (int rep = 0; rep < 5; rep++) begin
      for (int c = 0; c < 22; c++) begin
        logic er, ef, el, ez;
        signal = (c < 15);
        step();
        er = (c == 2);
        ef = (c == 17);
        el = (c >= 1 && c <= 15);
        ez = (c == 0 || c == 15);
        n_p += int'(m0_pulse); n_r += int'(m0_rise); n_f += int'(m0_fall);
        total++; if (m0_pulse !== er) begin bad++; $display("FAIL m0_pulse rep=%0d c=%0d got=%b exp=%b", rep, c, m0_pulse, er); end
        total++; if (m0_rise  !== er) begin bad++; $display("FAIL m0_rise rep=%0d c=%0d got=%b exp=%b", rep, c, m0_rise, er); end
        total++; if (m0_fall  !== ef) begin bad++; $display("FAIL m0_fall rep=%0d c=%0d got=%b exp=%b", rep, c, m0_fall, ef); end
        total++; if (m0_level !== el) begin bad++; $display("FAIL m0_level rep=%0d c=%0d got=%b exp=%b", rep, c, m0_level, el); end
        total++; if (z_pulse  !== ez) begin bad++; $display("FAIL z_pulse rep=%0d c=%0d got=%b exp=%b", rep, c, z_pulse, ez); end
      end
    end
    total++; if (n_p != 5) begin bad++; $display("FAIL m0_pulse_count got=%0d exp=5", n_p); end
    total++; if (n_r != 5) begin bad++; $display("FAIL m0_rise_count got=%0d exp=5", n_r); end
    total++; if (n_f != 5) begin bad++; $display("FAIL m0_fall_count got=%0d exp=5", n_f); end
    $display("test_mode_rise: pulses=%0d rises=%0d falls=%0d", n_p, n_r, n_f);
  endtask

  task automatic test_mode_fall();
    int n_p = 0;
    do_reset(1'b0);
    repeat (3) step();
    for (int rep = 0; rep < 5; rep++) begin
      for (int c = 0; c < 22; c++) begin
        logic ef;
        signal = (c < 15);
        step();
        ef = (c == 17);
        n_p += int'(m1_pulse);
        total++; if (m1_pulse !== ef) begin bad++; $display("FAIL m1_pulse rep=%0d c=%0d got=%b exp=%b", rep, c, m1_pulse, ef); end
      end
    end
    total++; if (n_p != 5) begin bad++; $display("FAIL m1_pulse_count got=%0d exp=5", n_p); end
    $display("test_mode_fall: pulses=%0d", n_p);
  endtask

  // MODE 2 with the input toggling every cycle for 10 cycles.
  task automatic test_both_toggle();
    int n_p = 0;
    do_reset(1'b0);
    repeat (3) step();
    for (int i = 0; i < 14; i++) begin
      logic ep, er, ef;
      if (i < 10) signal = ~signal;
      step();
      ep = (i >= 2 && i <= 11);
      er = ep && (((i - 2) % 2) == 0);
      ef = ep && !er;
      n_p += int'(m2_pulse);
      total++; if (m2_pulse !== ep) begin bad++; $display("FAIL m2_pulse i=%0d got=%b exp=%b", i, m2_pulse, ep); end
      total++; if (m2_rise  !== er) begin bad++; $display("FAIL m2_rise i=%0d got=%b exp=%b", i, m2_rise, er); end
      total++; if (m2_fall  !== ef) begin bad++; $display("FAIL m2_fall i=%0d got=%b exp=%b", i, m2_fall, ef); end
    end
    total++; if (n_p != 10) begin bad++; $display("FAIL m2_pulse_count got=%0d exp=10", n_p); end
    $display("test_both_toggle: pulses=%0d", n_p);
  endtask

  // Input high across reset release with RESET_LEVEL 0.
  task automatic test_reset_level();
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      logic ep, ez;
      step();
      ep = (i == 2);
      ez = (i == 0);
      total++; if (m0_pulse !== ep)   begin bad++; $display("FAIL rl_m0_pulse i=%0d got=%b exp=%b", i, m0_pulse, ep); end
      total++; if (m0_rise  !== ep)   begin bad++; $display("FAIL rl_m0_rise i=%0d got=%b exp=%b", i, m0_rise, ep); end
      total++; if (m1_pulse !== 1'b0) begin bad++; $display("FAIL rl_m1_pulse i=%0d got=%b exp=0", i, m1_pulse); end
      total++; if (z_pulse  !== ez)   begin bad++; $display("FAIL rl_z_pulse i=%0d got=%b exp=%b", i, z_pulse, ez); end
    end
    $display("test_reset_level: done");
  endtask

  // Reset during a falling pulse; input stays at the reset level afterwards.
  task automatic test_reset_mid_pulse();
    do_reset(1'b0);
    signal = 1'b1;
    repeat (8) step();
    signal = 1'b0;
    repeat (3) step();
    total++; if (m1_pulse !== 1'b1) begin bad++; $display("FAIL mid_pre_pulse got=%b exp=1", m1_pulse); end
    rst = 1'b1;
    #1;
    total++; if (m1_pulse !== 1'b0) begin bad++; $display("FAIL mid_async_pulse got=%b exp=0", m1_pulse); end
    total++; if (m1_fall  !== 1'b0) begin bad++; $display("FAIL mid_async_fall got=%b exp=0", m1_fall); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      total++; if (m1_pulse !== 1'b0) begin bad++; $display("FAIL mid_post_m1 i=%0d got=%b exp=0", i, m1_pulse); end
      total++; if (m0_pulse !== 1'b0) begin bad++; $display("FAIL mid_post_m0 i=%0d got=%b exp=0", i, m0_pulse); end
    end
    $display("test_reset_mid_pulse: done");
  endtask

`ifdef EDGE_DETECTOR_CNT_EN
  // CNT_W = 3: nine rising edges wrap to 1; clear beats a coincident pulse.
  task automatic test_counter();
    do_reset(1'b0);
    cnt_clr = 1'b0;
    repeat (3) step();
    total++; if (c_cnt !== 3'd0) begin bad++; $display("FAIL cnt_reset got=%0d exp=0", c_cnt); end
    for (int e = 0; e < 9; e++) begin
      signal = 1'b1;
      repeat (3) step();
      signal = 1'b0;
      repeat (3) step();
    end
    repeat (2) step();
    total++; if (c_cnt !== 3'd1) begin bad++; $display("FAIL cnt_wrap got=%0d exp=1", c_cnt); end
    signal = 1'b1;
    repeat (3) step();
    total++; if (c_pulse !== 1'b1) begin bad++; $display("FAIL cnt_pulse got=%b exp=1", c_pulse); end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    total++; if (c_cnt !== 3'd0) begin bad++; $display("FAIL cnt_clr_wins got=%0d exp=0", c_cnt); end
    step();
    total++; if (c_cnt !== 3'd0) begin bad++; $display("FAIL cnt_clr_hold got=%0d exp=0", c_cnt); end
    $display("test_counter: done");
  endtask
`endif

  initial begin
    test_reset();
    test_mode_rise();
    test_mode_fall();
    test_both_toggle();
    test_reset_level();
    test_reset_mid_pulse();
`ifdef EDGE_DETECTOR_CNT_EN
    test_counter();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_edge_detector_sync

// File: doc/edge_detector_sync.md
# edge_detector_sync

Single-bit edge detector turning level transitions on a (possibly asynchronous) input into one-clock-cycle pulses in the `clk` domain. It has a configurable synchroniser depth and selects rising, falling or both edges. It sits at the boundary between external/slow control lines (e.g. SPI chip-select, SCLK sampling) and synchronous control logic. An optional edge counter is available for debug.

## Interface
- `MODE`, default 0: edge select. 0 = rising, 1 = falling, 2 = both. Any other value is an elaboration error.
- `SYNC_STAGES`, default 2: synchroniser flops before detection. Legal range 0..4. 0 means the input is already synchronous to `clk`.
- `RESET_LEVEL`, default 1'b0: value loaded into the synchroniser and history flops by reset.
- `CNT_W`, default 16: edge counter width. Used only when the counter is compiled in.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset. Clears/loads all state immediately.
- `signal` in 1: monitored level.
- `pulse` out 1: registered one-cycle pulse on each edge selected by `MODE`.
- `rise` out 1: registered one-cycle pulse on every rising edge, regardless of `MODE`.
- `fall` out 1: registered one-cycle pulse on every falling edge, regardless of `MODE`.
- `level` out 1: synchronised copy of `signal`, i.e. the last synchroniser stage.
- `cnt_clr` in 1: synchronous clear of `edge_cnt`. Present only with `EDGE_DETECTOR_CNT_EN`.
- `edge_cnt` out `CNT_W`: count of `pulse` assertions. Present only with `EDGE_DETECTOR_CNT_EN`.

## Operation
- `signal` passes through `SYNC_STAGES` flops, giving `s`. A history flop `p` holds the previous value of `s`.
- Edge terms: rise_d = `s` & ~`p`; fall_d = ~`s` & `p`.
- Pulse selection: MODE 0 gives pulse_d = rise_d. MODE 1 gives fall_d. MODE 2 gives rise_d | fall_d.
- `pulse`, `rise` and `fall` are registered from these terms. They are never combinational from `signal`.
- Reset:
  - Synchroniser and `p` load `RESET_LEVEL`.
  - `pulse`, `rise` and `fall` go to 0; `edge_cnt` goes to 0; `level` equals `RESET_LEVEL`.
- If `signal` differs from `RESET_LEVEL` at reset release, the transition is detected as a normal edge. Example: `RESET_LEVEL` = 0 with `signal` high yields a rise pulse.
- Reset asserted mid-pulse clears `pulse` immediately. No pulse is generated by the reset itself.
- Each input transition that holds for at least `SYNC_STAGES`+1 cycles produces exactly one pulse.
- A glitch shorter than one clock may be missed or produce a rise/fall pair. This is acceptable and not filtered.
- A level held for N ≥ 1 sampled cycles followed by the opposite level yields distinct, non-merged pulses. Minimum spacing between pulses is one cycle, when MODE 2 sees toggling every cycle.

## Timing
- Let edge k be the first `clk` edge at which the new level of `signal` is sampled.
- `pulse` (and `rise` or `fall`) is high from edge k+`SYNC_STAGES` until edge k+`SYNC_STAGES`+1. Width is exactly one cycle.
- Default latency is 2 cycles. With `SYNC_STAGES` = 0 the pulse registers at edge k.
- `level` follows `signal` with `SYNC_STAGES` cycles of latency.
- `edge_cnt` increments on the edge after `pulse` is high, wrapping modulo 2^`CNT_W`.
- When `cnt_clr` and a counted pulse coincide, the clear wins and the result is 0.

## Configuration
- `EDGE_DETECTOR_CNT_EN` defined: `cnt_clr` and `edge_cnt` ports and the counter logic exist.
- `EDGE_DETECTOR_CNT_EN` undefined: those ports and that logic are absent. All other behaviour is identical.

## Structure
- Package `edge_detector_pkg`:
  - `edge_mode_e` enum: EDGE_RISE = 0, EDGE_FALL = 1, EDGE_BOTH = 2.
  - `SYNC_STAGES_MAX` = 4.
- `MODE` is compared against `edge_mode_e` values.
- One sub-module, `bit_sync`: a parameterised N-stage flop chain with async reset and reset value. It passes the input through directly when N = 0.
- Edge logic, output registers and counter stay in the top.

## Test plan
- Defaults, MODE 0; `rst` pulsed, `signal` = 0. Apply 5 repetitions of: high 15 cycles, low 7 cycles. Expect 5 `pulse`s, each 1 cycle wide, 2 cycles after each rising sample. Expect 5 `rise` and 5 `fall` pulses.
- Same stimulus with MODE 1: 5 `pulse`s, each 2 cycles after each falling sample. No `pulse` at the rising edges.
- MODE 2, `signal` toggling every cycle for 10 cycles: `pulse` high continuously for 10 cycles after 2 cycles of latency. `rise`/`fall` alternate.
- `RESET_LEVEL` = 0, `signal` held high through reset release: exactly one `rise`/`pulse` (MODE 0) at cycle 2 after release, then none.
- `rst` asserted while `pulse` = 1: `pulse` drops within the same cycle, without waiting for a clock edge. No pulse after release if `signal` is unchanged.
- `EDGE_DETECTOR_CNT_EN`, `CNT_W` = 3: 9 rising edges give `edge_cnt` = 1. `cnt_clr` coinciding with a pulse gives 0.
